afthb_scan_mux: RTL and testbench

Parametrised, registered N-channel input selector: the clocked successor to the project's combinational 4:1 bit mux. It selects one of `CH` channels of `W` bits each. The channel comes either from an external select (manual) or from an internal dwell-timed scanner (continuous or single sweep), with a freeze mode. It sits between the `ui_in`/`uio_in` pin fields and `uo_out` in the top-level wrapper.

---
 rtl/afthb_scan_mux.sv | 140 ++++++++++++++
 tb/tb_afthb_scan_mux.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/afthb_scan_mux.sv
// Registered CH-way channel selector with manual select, dwell-timed scanning,
// single-sweep and hold modes; all outputs come straight from flops.
module afthb_scan_mux #(
    parameter int CH      = 4,
    parameter int W       = 1,
    parameter int DWELL_W = 8,
    localparam int SW     = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CH*W-1:0]   din,
    input  logic [SW-1:0]     sel,
    input  logic [1:0]        mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [W-1:0]      dout,
    output logic [SW-1:0]     ch_out,
    output logic              valid,
    output logic              wrap,
    output logic              done
);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_SWEEP  = 2'b11
    } mode_e;

    localparam logic [SW-1:0] CH_LAST = SW'(CH - 1);

    logic [W-1:0]       dout_q, dout_d;
    logic [SW-1:0]      ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         prev_mode_q, prev_mode_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;

    mode_e              mode_cur;
    logic               entry;
    logic [W-1:0]       ch_data;
    logic [W-1:0]       sel_data;

    function automatic logic [W-1:0] pick(input logic [CH*W-1:0] bus, input logic [SW-1:0] idx);
        pick = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (idx == SW'(k)) pick = bus[k*W +: W];
        end
    endfunction

    always_comb begin
        mode_cur    = mode_e'(mode);
        entry       = (mode != prev_mode_q);
        ch_data     = pick(din, ch_q);
        sel_data    = pick(din, sel);

        dout_d      = dout_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        prev_mode_d = prev_mode_q;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        done_d      = done_q;

        if (ena) begin
            prev_mode_d = mode;
            if (mode_cur != MODE_SWEEP) done_d = 1'b0;
            case (mode_cur)
                MODE_MANUAL: begin
                    ch_d    = sel;
                    dout_d  = sel_data;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
                MODE_SCAN: begin
                    // Data is taken from the channel selected before this edge's advance.
                    dout_d  = ch_data;
                    valid_d = 1'b1;
                    if (entry) begin
                        cnt_d = '0;
                    end else if (cnt_q == dwell) begin
                        cnt_d  = '0;
                        ch_d   = ch_q + 1'b1;
                        wrap_d = (ch_q == CH_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_SWEEP: begin
                    if (entry) begin
                        ch_d    = '0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        dout_d  = ch_data;
                        valid_d = 1'b1;
                    end else if (!done_q) begin
                        dout_d  = ch_data;
                        valid_d = 1'b1;
                        if (cnt_q == dwell) begin
                            cnt_d = '0;
                            if (ch_q == CH_LAST) done_d = 1'b1;
                            else                 ch_d   = ch_q + 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            ch_q        <= '0;
            cnt_q       <= '0;
            prev_mode_q <= MODE_MANUAL;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            prev_mode_q <= prev_mode_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
        end
    end

    assign dout   = dout_q;
    assign ch_out = ch_q;
    assign valid  = valid_q;
    assign wrap   = wrap_q;
    assign done   = done_q;

endmodule

// File: tb/tb_afthb_scan_mux.sv
// Scoreboard bench for afthb_scan_mux: a CH=4/W=1 and a CH=8/W=4 instance share
// clock, reset and mode controls; expectations are queued per edge and checked after it.
module tb_afthb_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [1:0]  mode;
    logic [7:0]  dwell;

    logic [3:0]  din4;
    logic [1:0]  sel4;
    logic [0:0]  dout4;
    logic [1:0]  ch4;
    logic        valid4, wrap4, done4;

    logic [31:0] din8;
    logic [2:0]  sel8;
    logic [3:0]  dout8;
    logic [2:0]  ch8;
    logic        valid8, wrap8, done8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int    dut;
        string tag;
        int    dout;
        int    ch;
        bit    valid;
        bit    wrap;
        bit    done;
    } exp_t;

    exp_t sb[$];

    afthb_scan_mux #(.CH(4), .W(1), .DWELL_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din4), .sel(sel4), .mode(mode),
        .dwell(dwell), .dout(dout4), .ch_out(ch4), .valid(valid4), .wrap(wrap4), .done(done4)
    );

    afthb_scan_mux #(.CH(8), .W(4), .DWELL_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din8), .sel(sel8), .mode(mode),
        .dwell(dwell), .dout(dout8), .ch_out(ch8), .valid(valid8), .wrap(wrap8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int d4(input int c);
        return int'(din4[c]);
    endfunction

    function automatic int d8(input int c);
        return int'(din8[c*4 +: 4]);
    endfunction

    task automatic push(input int dut, input string tag, input int d, input int c,
                        input bit v, input bit w, input bit dn);
        exp_t e;
        e.dut = dut; e.tag = tag; e.dout = d; e.ch = c;
        e.valid = v; e.wrap = w; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 4) begin
                check({e.tag, ".dout4"},  32'(dout4),  32'(e.dout));
                check({e.tag, ".ch4"},    32'(ch4),    32'(e.ch));
                check({e.tag, ".valid4"}, 32'(valid4), 32'(e.valid));
                check({e.tag, ".wrap4"},  32'(wrap4),  32'(e.wrap));
                check({e.tag, ".done4"},  32'(done4),  32'(e.done));
            end else begin
                check({e.tag, ".dout8"},  32'(dout8),  32'(e.dout));
                check({e.tag, ".ch8"},    32'(ch8),    32'(e.ch));
                check({e.tag, ".valid8"}, 32'(valid8), 32'(e.valid));
                check({e.tag, ".wrap8"},  32'(wrap8),  32'(e.wrap));
                check({e.tag, ".done8"},  32'(done8),  32'(e.done));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    // Sweep reference: after edge k (k=0 is entry) with N = nch*(d+1) edges to completion.
    function automatic int sw_ch(input int k, input int d, input int nch);
        if (k >= nch * (d + 1)) return nch - 1;
        return k / (d + 1);
    endfunction

    task automatic sweep_run(input int k0, input int k1, input int d,
                             input int pre4, input int pre8, input bit chk8);
        int n4, n8, dv4, dv8;
        n4 = 4 * (d + 1);
        n8 = 8 * (d + 1);
        for (int k = k0; k <= k1; k++) begin
            dv4 = (k == 0) ? d4(pre4) : d4(sw_ch(k - 1, d, 4));
            push(4, $sformatf("swp%0d", k), dv4, sw_ch(k, d, 4), k <= n4, 1'b0, k >= n4);
            if (chk8) begin
                dv8 = (k == 0) ? d8(pre8) : d8(sw_ch(k - 1, d, 8));
                push(8, $sformatf("swp%0d", k), dv8, sw_ch(k, d, 8), k <= n8, 1'b0, k >= n8);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b1; ena = 1'b1; mode = 2'b00; dwell = 8'd0;
        din4 = 4'b1010; sel4 = 2'd1;
        din8 = 32'h9ABC_DEF5; sel8 = 3'd5;
        #1 rst_n = 1'b0;
        #2;
        push(4, "rst", 0, 0, 0, 0, 0);
        push(8, "rst", 0, 0, 0, 0, 0);
        drain();
        #1 rst_n = 1'b1;

        // Manual select, one edge latency
        push(4, "man1", d4(1), 1, 1, 0, 0);
        push(8, "man5", d8(5), 5, 1, 0, 0);
        tick();
        sel4 = 2'd2; sel8 = 3'd3;
        push(4, "man2", d4(2), 2, 1, 0, 0);
        push(8, "man3", d8(3), 3, 1, 0, 0);
        tick();
        sel4 = 2'd0;
        push(4, "man0", d4(0), 0, 1, 0, 0);
        tick();

        // Scan with dwell=2 from channel 0
        mode = 2'b01; dwell = 8'd2;
        for (int k = 0; k <= 12; k++) begin
            int c, pc;
            c  = (k / 3) % 4;
            pc = (k == 0) ? 0 : ((k - 1) / 3) % 4;
            push(4, $sformatf("scn%0d", k), d4(pc), c, 1, (k > 0) && (k % 3 == 0) && (c == 0), 0);
            tick();
        end

        // Scan with dwell=0 advances every edge
        dwell = 8'd0;
        for (int j = 1; j <= 8; j++) begin
            push(4, $sformatf("dw0_%0d", j), d4((j - 1) % 4), j % 4, 1, (j % 4) == 0, 0);
            tick();
        end

        // Mid-scan hold, then resume
        dwell = 8'd2;
        push(4, "pre1", d4(0), 0, 1, 0, 0); tick();
        push(4, "pre2", d4(0), 0, 1, 0, 0); tick();
        push(4, "pre3", d4(0), 1, 1, 0, 0); tick();
        push(4, "pre4", d4(1), 1, 1, 0, 0); tick();
        mode = 2'b10;
        for (int j = 0; j < 5; j++) begin
            push(4, $sformatf("hold%0d", j), d4(1), 1, 0, 0, 0);
            tick();
        end
        mode = 2'b01;
        push(4, "res0", d4(1), 1, 1, 0, 0); tick();
        push(4, "res1", d4(1), 1, 1, 0, 0); tick();
        push(4, "res2", d4(1), 1, 1, 0, 0); tick();
        push(4, "res3", d4(1), 2, 1, 0, 0); tick();

        // ena low freezes everything including prev_mode
        ena = 1'b0;
        for (int j = 0; j < 3; j++) begin
            push(4, $sformatf("ena%0d", j), d4(1), 2, 0, 0, 0);
            tick();
        end
        ena = 1'b1;
        push(4, "ena_r1", d4(2), 2, 1, 0, 0); tick();
        push(4, "ena_r2", d4(2), 2, 1, 0, 0); tick();
        push(4, "ena_r3", d4(2), 3, 1, 0, 0); tick();

        // Sweep with dwell=1, then manual clears done
        mode = 2'b11; dwell = 8'd1;
        sweep_run(0, 10, 1, 3, 0, 1'b0);
        mode = 2'b00; sel4 = 2'd2; sel8 = 3'd6;
        push(4, "clr", d4(2), 2, 1, 0, 0);
        push(8, "clr", d8(6), 6, 1, 0, 0);
        tick();

        // Async reset mid-sweep at ch=2 on both widths
        mode = 2'b11;
        sweep_run(0, 4, 1, 2, 6, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        push(4, "arst", 0, 0, 0, 0, 0);
        push(8, "arst", 0, 0, 0, 0, 0);
        drain();
        #1 rst_n = 1'b1;
        sweep_run(0, 17, 1, 0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
